// File: rtl/projeto_200917_dado_display.sv
// Dice display controller: on a new die value from the PIO it plays a timed rolling
// animation on the 7-seg digit and pip LEDs, then settles on the final face.
module projeto_200917_dado_display #(
   parameter int unsigned STEP_CYCLES = 2500000,
   parameter int unsigned ROLL_STEPS  = 12
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] dado_value,
   output logic [6:0] hex_n,
   output logic [6:0] pips,
   output logic       busy,
   output logic       roll_done
);

   // state | meaning
   // BLANK | value 0, all segments and pips off
   // ERR   | value 7..15, dash on the digit, pips off
   // ROLL  | animation running, face cycles 1..6 every STEP_CYCLES clks
   // SHOW  | final face of the written value, held until the value changes

   localparam int TICK_W = $clog2(STEP_CYCLES + 1);
   localparam int STEP_W = $clog2(ROLL_STEPS + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ROLL_STEPS - 1);

   localparam logic [6:0] HEX_BLANK = 7'h7F;
   localparam logic [6:0] HEX_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_ERR   = 2'd1,
      ST_ROLL  = 2'd2,
      ST_SHOW  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        v_q;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [2:0]        face_q, face_d;
   logic [6:0]        hex_n_q, hex_n_d;
   logic [6:0]        pips_q, pips_d;
   logic              busy_q, busy_d;
   logic              roll_done_q, roll_done_d;
   logic              chg;

   function automatic logic [6:0] face_hex(input logic [3:0] f);
      case (f)
         4'd1:    face_hex = 7'h79;
         4'd2:    face_hex = 7'h24;
         4'd3:    face_hex = 7'h30;
         4'd4:    face_hex = 7'h19;
         4'd5:    face_hex = 7'h12;
         4'd6:    face_hex = 7'h02;
         default: face_hex = HEX_BLANK;
      endcase
   endfunction

   function automatic logic [6:0] face_pips(input logic [3:0] f);
      case (f)
         4'd1:    face_pips = 7'h08;
         4'd2:    face_pips = 7'h41;
         4'd3:    face_pips = 7'h49;
         4'd4:    face_pips = 7'h63;
         4'd5:    face_pips = 7'h6B;
         4'd6:    face_pips = 7'h77;
         default: face_pips = 7'h00;
      endcase
   endfunction

   assign chg = (dado_value != v_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_BLANK;
         v_q         <= 4'd0;
         tick_q      <= '0;
         step_q      <= '0;
         face_q      <= 3'd1;
         hex_n_q     <= HEX_BLANK;
         pips_q      <= 7'h00;
         busy_q      <= 1'b0;
         roll_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_q         <= dado_value;
         tick_q      <= tick_d;
         step_q      <= step_d;
         face_q      <= face_d;
         hex_n_q     <= hex_n_d;
         pips_q      <= pips_d;
         busy_q      <= busy_d;
         roll_done_q <= roll_done_d;
      end
   end

   // A value change wins in every state; a valid value always restarts the animation.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      step_d  = step_q;
      face_d  = face_q;
      if (chg) begin
         if (dado_value == 4'd0) begin
            state_d = ST_BLANK;
         end else if (dado_value > 4'd6) begin
            state_d = ST_ERR;
         end else begin
            state_d = ST_ROLL;
            tick_d  = '0;
            step_d  = '0;
            face_d  = 3'd1;
         end
      end else if (state_q == ST_ROLL) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (step_q == STEP_LAST) begin
               state_d = ST_SHOW;
            end else begin
               step_d = step_q + 1'b1;
               face_d = (face_q == 3'd6) ? 3'd1 : face_q + 3'd1;
            end
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // Outputs are precomputed from the next state so they change on the same edge.
   always_comb begin
      hex_n_d     = HEX_BLANK;
      pips_d      = 7'h00;
      busy_d      = 1'b0;
      roll_done_d = 1'b0;
      case (state_d)
         ST_ERR: begin
            hex_n_d = HEX_DASH;
         end
         ST_ROLL: begin
            hex_n_d = face_hex({1'b0, face_d});
            pips_d  = face_pips({1'b0, face_d});
            busy_d  = 1'b1;
         end
         ST_SHOW: begin
            hex_n_d     = face_hex(v_q);
            pips_d      = face_pips(v_q);
            roll_done_d = (state_q == ST_ROLL);
         end
         default: begin
            hex_n_d = HEX_BLANK;
         end
      endcase
   end

   assign hex_n     = hex_n_q;
   assign pips      = pips_q;
   assign busy      = busy_q;
   assign roll_done = roll_done_q;

endmodule

// File: tb/tb_projeto_200917_dado_display.sv
// Directed bench for the dice display controller with a short animation
// (4 clks per frame, 3 frames); expected faces come from a hand-written table.
module tb_projeto_200917_dado_display;

   localparam int STEP = 4;
   localparam int ROLLS = 3;

   logic       clk;
   logic       reset_n;
   logic [3:0] dado_value;
   logic [6:0] hex_n;
   logic [6:0] pips;
   logic       busy;
   logic       roll_done;

   int n_checks = 0;
   int n_errors = 0;

   projeto_200917_dado_display #(
      .STEP_CYCLES(STEP),
      .ROLL_STEPS (ROLLS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .dado_value(dado_value),
      .hex_n     (hex_n),
      .pips      (pips),
      .busy      (busy),
      .roll_done (roll_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_hex(input int f);
      case (f)
         1: exp_hex = 7'h79;
         2: exp_hex = 7'h24;
         3: exp_hex = 7'h30;
         4: exp_hex = 7'h19;
         5: exp_hex = 7'h12;
         6: exp_hex = 7'h02;
         default: exp_hex = 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] exp_pips(input int f);
      case (f)
         1: exp_pips = 7'h08;
         2: exp_pips = 7'h41;
         3: exp_pips = 7'h49;
         4: exp_pips = 7'h63;
         5: exp_pips = 7'h6B;
         6: exp_pips = 7'h77;
         default: exp_pips = 7'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [6:0] h, input logic [6:0] p,
                            input logic b, input logic d);
      check({tag, ".hex_n"}, 32'(hex_n), 32'(h));
      check({tag, ".pips"}, 32'(pips), 32'(p));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".roll_done"}, 32'(roll_done), 32'(d));
   endtask

   // Advance one clk and land on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called on the falling edge just after the edge that entered ROLL.
   task automatic expect_roll(input string tag, input int v);
      for (int i = 0; i < STEP * ROLLS; i++) begin
         check_out(tag, exp_hex(1 + (i / STEP) % 6), exp_pips(1 + (i / STEP) % 6), 1'b1, 1'b0);
         step();
      end
      check_out({tag, "_show"}, exp_hex(v), exp_pips(v), 1'b0, 1'b1);
      step();
      check_out({tag, "_hold"}, exp_hex(v), exp_pips(v), 1'b0, 1'b0);
   endtask

   initial begin
      reset_n    = 1'b0;
      dado_value = 4'd0;
      #22;
      check_out("in_reset", 7'h7F, 7'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check_out("idle_blank", 7'h7F, 7'h00, 1'b0, 1'b0);
      end

      // 0 -> 5: full roll
      dado_value = 4'd5;
      step();
      expect_roll("roll5", 5);

      // 0 -> 5, then 5 -> 3 at k+6
      dado_value = 4'd0;
      step();
      check_out("blank_a", 7'h7F, 7'h00, 1'b0, 1'b0);
      dado_value = 4'd5;
      step();
      for (int i = 0; i < 6; i++) begin
         check_out("roll5_part", exp_hex(1 + i / STEP), exp_pips(1 + i / STEP), 1'b1, 1'b0);
         step();
      end
      dado_value = 4'd3;
      @(posedge clk);
      @(negedge clk);
      expect_roll("reroll3", 3);

      // 0 -> 2, then 2 -> 9 at k+5
      dado_value = 4'd0;
      step();
      dado_value = 4'd2;
      step();
      for (int i = 0; i < 5; i++) begin
         check_out("roll2_part", exp_hex(1 + i / STEP), exp_pips(1 + i / STEP), 1'b1, 1'b0);
         step();
      end
      dado_value = 4'd9;
      step();
      for (int i = 0; i < 6; i++) begin
         check_out("err9", 7'h3F, 7'h00, 1'b0, 1'b0);
         step();
      end
      dado_value = 4'd15;
      step();
      check_out("err15", 7'h3F, 7'h00, 1'b0, 1'b0);
      dado_value = 4'd0;
      step();
      check_out("blank_b", 7'h7F, 7'h00, 1'b0, 1'b0);

      // roll to 6, rewrite 6 (no change), then 6 -> 0 -> 6
      dado_value = 4'd6;
      step();
      expect_roll("roll6", 6);
      for (int i = 0; i < 20; i++) begin
         dado_value = 4'd6;
         step();
         check_out("show6_hold", 7'h02, 7'h77, 1'b0, 1'b0);
      end
      dado_value = 4'd0;
      step();
      check_out("blank_c", 7'h7F, 7'h00, 1'b0, 1'b0);
      dado_value = 4'd6;
      step();
      expect_roll("roll6b", 6);

      // value 4 held, reset pulsed at roll step 2
      dado_value = 4'd0;
      step();
      dado_value = 4'd4;
      step();
      for (int i = 0; i < 9; i++) begin
         check_out("roll4_part", exp_hex(1 + i / STEP), exp_pips(1 + i / STEP), 1'b1, 1'b0);
         step();
      end
      reset_n = 1'b0;
      #1;
      check_out("async_reset", 7'h7F, 7'h00, 1'b0, 1'b0);
      step();
      check_out("reset_held", 7'h7F, 7'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      step();
      expect_roll("roll4_after_reset", 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
